// File: rtl/prm2bits_seq_pkg.sv
// Shared constants, state encodings and the per-parameter bit-count ROM
// for the G.729 parameter-to-bitstream packer.
package prm2bits_seq_pkg;

   localparam logic [11:0] SERIAL    = 12'h200;
   localparam logic [11:0] PRM       = 12'h0f0;
   localparam int          PRM_SIZE  = 11;
   localparam logic [15:0] SYNC_WORD = 16'h6b21;
   localparam logic [15:0] SIZE_WORD = 16'd80;
   localparam logic [15:0] BIT_0     = 16'h007f;
   localparam logic [15:0] BIT_1     = 16'h0081;

   typedef enum logic [3:0] {
      S_IDLE, S_SYNC, S_SIZE, S_RD, S_LATCH, S_START, S_WAIT, S_ADVANCE, S_DONE
   } seq_state_t;

   typedef enum logic [2:0] {
      B_INIT, B_SETUP, B_DEC, B_WRITE, B_NEXT, B_DONE
   } bin_state_t;

   function automatic logic [15:0] bit_count(input logic [3:0] k);
      case (k)
         4'd0:    bit_count = 16'd8;
         4'd1:    bit_count = 16'd10;
         4'd2:    bit_count = 16'd8;
         4'd3:    bit_count = 16'd1;
         4'd4:    bit_count = 16'd13;
         4'd5:    bit_count = 16'd4;
         4'd6:    bit_count = 16'd7;
         4'd7:    bit_count = 16'd5;
         4'd8:    bit_count = 16'd13;
         4'd9:    bit_count = 16'd4;
         4'd10:   bit_count = 16'd7;
         default: bit_count = 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/prm2bits_seq_int2bin.sv
// Serialises the low bitsno bits of value into SERIAL as BIT_0/BIT_1 words,
// LSB first, from address bitstream+bitsno-1 down to bitstream.
//
// state   | meaning
// INIT    | idle; latch value/bitsno/bitstream on start
// SETUP   | pos = bitstream + bitsno (adder)
// DEC     | pos = pos - 1 (subtractor), now the LSB address
// WRITE   | write current bit word, cnt = cnt - 1, shift value
// NEXT    | all bits written -> DONE, else pos = pos - 1
// DONE    | done pulse, back to INIT
module int2bin
   import prm2bits_seq_pkg::*;
#(
   parameter logic [11:0] SERIAL_BASE = SERIAL
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] value,
   input  logic [15:0] bitsno,
   input  logic [15:0] bitstream,
   output logic        done,
   output logic [15:0] add_outa,
   output logic [15:0] add_outb,
   input  logic [15:0] add_in,
   output logic [15:0] sub_outa,
   output logic [15:0] sub_outb,
   input  logic [15:0] sub_in,
   output logic [11:0] scratch_mem_write_addr,
   output logic [31:0] scratch_mem_out,
   output logic        scratch_mem_write_en
);

   bin_state_t  state;
   logic [15:0] shift;
   logic [15:0] cnt;
   logic [15:0] pos;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= B_INIT;
         shift <= 16'd0;
         cnt   <= 16'd0;
         pos   <= 16'd0;
         done  <= 1'b0;
      end else begin
         case (state)
            B_INIT: if (start) begin
               shift <= value;
               cnt   <= bitsno;
               pos   <= bitstream;
               state <= B_SETUP;
            end
            B_SETUP: begin
               pos   <= add_in;
               state <= B_DEC;
            end
            B_DEC: begin
               pos   <= sub_in;
               state <= B_WRITE;
            end
            B_WRITE: begin
               cnt   <= sub_in;
               shift <= {1'b0, shift[15:1]};
               state <= B_NEXT;
            end
            B_NEXT: begin
               if (cnt == 16'd0) begin
                  done  <= 1'b1;
                  state <= B_DONE;
               end else begin
                  pos   <= sub_in;
                  state <= B_WRITE;
               end
            end
            B_DONE: begin
               done  <= 1'b0;
               state <= B_INIT;
            end
            default: state <= B_INIT;
         endcase
      end
   end

   always_comb begin
      add_outa               = 16'd0;
      add_outb               = 16'd0;
      sub_outa               = 16'd0;
      sub_outb               = 16'd0;
      scratch_mem_write_addr = 12'd0;
      scratch_mem_out        = 32'd0;
      scratch_mem_write_en   = 1'b0;
      case (state)
         B_SETUP: begin
            add_outa = pos;
            add_outb = cnt;
         end
         B_DEC: begin
            sub_outa = pos;
            sub_outb = 16'd1;
         end
         B_WRITE: begin
            sub_outa               = cnt;
            sub_outb               = 16'd1;
            // SERIAL is 128-word aligned, so the offset simply fills the low bits
            scratch_mem_write_addr = {SERIAL_BASE[11:7], pos[6:0]};
            scratch_mem_out        = {16'd0, shift[0] ? BIT_1 : BIT_0};
            scratch_mem_write_en   = 1'b1;
         end
         B_NEXT: if (cnt != 16'd0) begin
            sub_outa = pos;
            sub_outb = 16'd1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/prm2bits_seq.sv
// Frame-level sequencer: writes the SERIAL header, then feeds each PRM word
// through int2bin, lending it the shared adder/subtractor/memory port.
//
// state   | meaning
// IDLE    | wait for start
// SYNC    | write sync word to SERIAL+0
// SIZE    | write size word to SERIAL+1
// RD      | read prm[k]
// LATCH   | capture read data into val
// START   | pulse int2bin start
// WAIT    | int2bin owns shared resources until its done
// ADVANCE | ptr += table[k]; next k or finish
// DONE    | done pulse, clear registers
module prm2bits_seq
   import prm2bits_seq_pkg::*;
#(
   parameter logic [11:0] PRM_BASE    = PRM,
   parameter logic [11:0] SERIAL_BASE = SERIAL
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        done,
   output logic [15:0] add_outa,
   output logic [15:0] add_outb,
   input  logic [15:0] add_in,
   output logic [15:0] sub_outa,
   output logic [15:0] sub_outb,
   input  logic [15:0] sub_in,
   output logic [11:0] scratch_mem_read_addr,
   input  logic [31:0] scratch_mem_in,
   output logic [11:0] scratch_mem_write_addr,
   output logic [31:0] scratch_mem_out,
   output logic        scratch_mem_write_en
);

   seq_state_t  state;
   logic [3:0]  k;
   logic [15:0] ptr;
   logic [15:0] val;

   logic        child_start;
   logic        child_done;
   logic        child_owns;
   logic [15:0] c_add_a, c_add_b, c_sub_a, c_sub_b;
   logic [11:0] c_waddr;
   logic [31:0] c_wdata;
   logic        c_we;

   logic [15:0] s_add_a, s_add_b;
   logic [11:0] s_raddr, s_waddr;
   logic [31:0] s_wdata;
   logic        s_we;

   logic        unused_hi;
   assign unused_hi = ^scratch_mem_in[31:16];

   assign child_start = (state == S_START);
   assign child_owns  = (state == S_START) || (state == S_WAIT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         k     <= 4'd0;
         ptr   <= 16'd0;
         val   <= 16'd0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               k     <= 4'd0;
               ptr   <= 16'd2;
               state <= S_SYNC;
            end
            S_SYNC:  state <= S_SIZE;
            S_SIZE:  state <= S_RD;
            S_RD:    state <= S_LATCH;
            S_LATCH: begin
               val   <= scratch_mem_in[15:0];
               state <= S_START;
            end
            S_START: state <= S_WAIT;
            S_WAIT:  if (child_done) state <= S_ADVANCE;
            S_ADVANCE: begin
               ptr <= add_in;
               if (k == 4'(PRM_SIZE - 1)) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  k     <= k + 4'd1;
                  state <= S_RD;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               k     <= 4'd0;
               ptr   <= 16'd0;
               val   <= 16'd0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      s_add_a = 16'd0;
      s_add_b = 16'd0;
      s_raddr = 12'd0;
      s_waddr = 12'd0;
      s_wdata = 32'd0;
      s_we    = 1'b0;
      case (state)
         S_SYNC: begin
            s_waddr = SERIAL_BASE;
            s_wdata = {16'd0, SYNC_WORD};
            s_we    = 1'b1;
         end
         S_SIZE: begin
            s_waddr = SERIAL_BASE + 12'd1;
            s_wdata = {16'd0, SIZE_WORD};
            s_we    = 1'b1;
         end
         S_RD: s_raddr = PRM_BASE + {8'd0, k};
         S_ADVANCE: begin
            s_add_a = ptr;
            s_add_b = bit_count(k);
         end
         default: ;
      endcase
   end

   assign add_outa               = child_owns ? c_add_a : s_add_a;
   assign add_outb               = child_owns ? c_add_b : s_add_b;
   assign sub_outa               = child_owns ? c_sub_a : 16'd0;
   assign sub_outb               = child_owns ? c_sub_b : 16'd0;
   assign scratch_mem_read_addr  = child_owns ? 12'd0   : s_raddr;
   assign scratch_mem_write_addr = child_owns ? c_waddr : s_waddr;
   assign scratch_mem_out        = child_owns ? c_wdata : s_wdata;
   assign scratch_mem_write_en   = child_owns ? c_we    : s_we;

   int2bin #(
      .SERIAL_BASE(SERIAL_BASE)
   ) u_int2bin (
      .clock                  (clock),
      .reset                  (reset),
      .start                  (child_start),
      .value                  (val),
      .bitsno                 (bit_count(k)),
      .bitstream              (ptr),
      .done                   (child_done),
      .add_outa               (c_add_a),
      .add_outb               (c_add_b),
      .add_in                 (add_in),
      .sub_outa               (c_sub_a),
      .sub_outb               (c_sub_b),
      .sub_in                 (sub_in),
      .scratch_mem_write_addr (c_waddr),
      .scratch_mem_out        (c_wdata),
      .scratch_mem_write_en   (c_we)
   );

endmodule

// File: tb/tb_prm2bits_seq.sv
// Scoreboard bench for prm2bits_seq: expected SERIAL writes and done cycles
// are queued per frame and popped by a monitor as the DUT produces them.
module tb_prm2bits_seq;
   import prm2bits_seq_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        done;
   logic [15:0] add_outa, add_outb, add_in;
   logic [15:0] sub_outa, sub_outb, sub_in;
   logic [11:0] scratch_mem_read_addr, scratch_mem_write_addr;
   logic [31:0] scratch_mem_in, scratch_mem_out;
   logic        scratch_mem_write_en;

   prm2bits_seq dut (
      .clock                  (clock),
      .reset                  (reset),
      .start                  (start),
      .done                   (done),
      .add_outa               (add_outa),
      .add_outb               (add_outb),
      .add_in                 (add_in),
      .sub_outa               (sub_outa),
      .sub_outb               (sub_outb),
      .sub_in                 (sub_in),
      .scratch_mem_read_addr  (scratch_mem_read_addr),
      .scratch_mem_in         (scratch_mem_in),
      .scratch_mem_write_addr (scratch_mem_write_addr),
      .scratch_mem_out        (scratch_mem_out),
      .scratch_mem_write_en   (scratch_mem_write_en)
   );

   always #5 clock = ~clock;

   assign add_in = add_outa + add_outb;
   assign sub_in = sub_outa - sub_outb;

   logic [31:0] mem [0:4095];
   always @(posedge clock) begin
      if (scratch_mem_write_en) mem[scratch_mem_write_addr] = scratch_mem_out;
   end
   always @(posedge clock) scratch_mem_in <= mem[scratch_mem_read_addr];

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         wr_q[$];
   int          done_q[$];
   wr_t         exp_wr;
   int          exp_cyc;
   int          errors = 0;
   int          checks = 0;
   int          tbl [11] = '{8, 10, 8, 1, 13, 4, 7, 5, 13, 4, 7};
   logic [15:0] prm_v [11];

   always @(negedge clock) begin
      if (scratch_mem_write_en) begin
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected cyc=%0d addr=%h data=%h", cyc,
                     scratch_mem_write_addr, scratch_mem_out);
         end else begin
            exp_wr = wr_q.pop_front();
            if (scratch_mem_write_addr !== exp_wr.addr || scratch_mem_out !== exp_wr.data) begin
               errors++;
               $display("FAIL wr_data cyc=%0d actual=%h:%h required=%h:%h", cyc,
                        scratch_mem_write_addr, scratch_mem_out, exp_wr.addr, exp_wr.data);
            end
         end
      end
      if (done) begin
         checks++;
         if (done_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected cyc=%0d", cyc);
         end else begin
            exp_cyc = done_q.pop_front();
            if (cyc != exp_cyc) begin
               errors++;
               $display("FAIL done_cycle actual=%0d required=%0d", cyc, exp_cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, {done, add_outa, add_outb, sub_outa, sub_outb, scratch_mem_read_addr,
                   scratch_mem_write_addr, scratch_mem_out, scratch_mem_write_en}, 128'd0);
   endtask

   task automatic load_mem();
      for (int i = 0; i < 128; i++) mem[SERIAL + 12'(i)] = 32'hdeadbeef;
      for (int j = 0; j < 11; j++) mem[PRM + 12'(j)] = {16'hcafe, prm_v[j]};
   endtask

   task automatic push_frame();
      int p = 2;
      wr_q.push_back('{SERIAL, 32'h0000_6b21});
      wr_q.push_back('{SERIAL + 12'd1, 32'h0000_0050});
      for (int j = 0; j < 11; j++) begin
         for (int i = 0; i < tbl[j]; i++)
            wr_q.push_back('{SERIAL + 12'(p + tbl[j] - 1 - i),
                             prm_v[j][i] ? 32'h0000_0081 : 32'h0000_007f});
         p += tbl[j];
      end
   endtask

   task automatic run_frame(input int extra_start, input int reset_at);
      int t0;
      load_mem();
      push_frame();
      @(posedge clock); #1;
      start = 1'b1;
      t0 = cyc;
      if (reset_at < 0) done_q.push_back(t0 + 240);
      @(posedge clock); #1;
      start = 1'b0;
      for (int c = 1; c < 250; c++) begin
         start = (c == extra_start);
         if (c == reset_at) reset = 1'b1;
         if (c == reset_at + 1) begin
            reset = 1'b0;
            check_outputs_zero("reset_mid_outputs");
            wr_q.delete();
         end
         @(posedge clock); #1;
      end
      check("wr_queue_drained", 128'(wr_q.size()), 128'd0);
      check("done_queue_drained", 128'(done_q.size()), 128'd0);
      wr_q.delete();
      done_q.delete();
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int j = 0; j < 11; j++) prm_v[j] = v;
   endtask

   initial begin
      set_all(16'h0000);
      repeat (3) @(posedge clock);
      #1;
      check_outputs_zero("reset_outputs");
      reset = 1'b0;
      @(posedge clock); #1;
      check_outputs_zero("idle_outputs");

      set_all(16'h0000);
      run_frame(-10, -10);
      check("zero_serial2", 128'(mem[SERIAL + 12'd2]), 128'h7f);

      set_all(16'hffff);
      run_frame(-10, -10);
      check("ones_serial81", 128'(mem[SERIAL + 12'd81]), 128'h81);
      check("ones_serial82_untouched", 128'(mem[SERIAL + 12'd82]), 128'hdeadbeef);

      set_all(16'h0000);
      prm_v[0] = 16'h0001;
      run_frame(-10, -10);
      check("prm0_lsb_serial9", 128'(mem[SERIAL + 12'd9]), 128'h81);
      check("prm0_serial8", 128'(mem[SERIAL + 12'd8]), 128'h7f);

      set_all(16'h0000);
      prm_v[3] = 16'h0001;
      run_frame(-10, -10);
      check("prm3_serial28", 128'(mem[SERIAL + 12'd28]), 128'h81);

      prm_v = '{16'h00a5, 16'h02c3, 16'h005a, 16'h0001, 16'h1abc, 16'h0009,
                16'h0055, 16'h0013, 16'h0f0f, 16'h0006, 16'h007b};
      run_frame(-10, -10);

      set_all(16'h0000);
      run_frame(95, -10);

      prm_v = '{16'h00a5, 16'h02c3, 16'h005a, 16'h0001, 16'h1abc, 16'h0009,
                16'h0055, 16'h0013, 16'h0f0f, 16'h0006, 16'h007b};
      run_frame(-10, 100);
      check_outputs_zero("after_reset_idle");

      set_all(16'hffff);
      prm_v[5] = 16'h000a;
      run_frame(-10, -10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
